// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin grant arbiter with hold budget and one-hot mux select
module rr_grant_arbiter #(
    parameter int NR_REQ    = 4,
    parameter int IDX_WIDTH = 2,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NR_REQ-1:0]    req,
    input  logic                 done,
    output logic [NR_REQ-1:0]    grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 preempt
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(NR_REQ - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NR_REQ-1:0]    grant_q, grant_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                 preempt_q, preempt_d;

    logic [IDX_WIDTH-1:0] owner_next;
    logic [IDX_WIDTH-1:0] search_start;
    logic [NR_REQ-1:0]    search_req;
    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [NR_REQ-1:0]    win_onehot;

    logic                 rel_done;
    logic                 rel_abandon;
    logic                 others_pending;
    logic                 rel_hold;
    logic                 release_now;

    assign owner_next = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;

    // While busy the search only matters on release, where the owner is masked
    // and the scan starts just past it; from idle it starts at ptr unmasked.
    always_comb begin
        search_start = ptr_q;
        search_req   = req;
        if (state_q == ST_BUSY) begin
            search_start = owner_next;
            search_req   = req & ~grant_q;
        end
    end

    always_comb begin
        int cand;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            cand = (int'(search_start) + i) % NR_REQ;
            if (!win_found && search_req[IDX_WIDTH'(cand)]) begin
                win_found                     = 1'b1;
                win_idx                       = IDX_WIDTH'(cand);
                win_onehot[IDX_WIDTH'(cand)]  = 1'b1;
            end
        end
    end

    always_comb begin
        rel_done       = done;
        rel_abandon    = ~|(req & grant_q);
        others_pending = |(req & ~grant_q);
        rel_hold       = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && others_pending;
        release_now    = rel_done || rel_abandon || rel_hold;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_BUSY;
                    grant_d     = win_onehot;
                    grant_idx_d = win_idx;
                    hold_cnt_d  = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    ptr_d      = owner_next;
                    preempt_d  = rel_hold && !rel_done && !rel_abandon;
                    hold_cnt_d = '0;
                    if (win_found) begin
                        grant_d     = win_onehot;
                        grant_idx_d = win_idx;
                    end else begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = (state_q == ST_BUSY);
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int checks;
    int failures;

    rr_grant_arbiter #(
        .NR_REQ   (4),
        .IDX_WIDTH(2),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                              input logic v, input logic p);
        check({tag, ".grant"},   32'(grant),       32'(g));
        check({tag, ".idx"},     32'(grant_idx),   32'(idx));
        check({tag, ".valid"},   32'(grant_valid), 32'(v));
        check({tag, ".preempt"}, 32'(preempt),     32'(p));
    endtask

    logic [3:0] rot_g [7];
    logic [1:0] rot_i [7];

    initial begin
        checks   = 0;
        failures = 0;
        rot_g = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rot_i = '{2'd3,    2'd0,    2'd1,    2'd2,    2'd3,    2'd0,    2'd1};

        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #2;
        step();
        step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        rst_n = 1'b1;
        step();
        expect_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        req = 4'b0000;
        step();
        expect_out("abandon_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // single requester held well past the hold budget: no preemption
        req = 4'b0100;
        step();
        expect_out("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("single_hold.grant", 32'(grant), 32'(4'b0100));
            check("single_hold.preempt", 32'(preempt), 32'(1'b0));
        end
        req  = 4'b0000;
        done = 1'b1;
        step();
        expect_out("single_done", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ptr is now 3; done stays high and is ignored while idle
        req = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            step();
            expect_out("rotation", rot_g[i], rot_i[i], 1'b1, 1'b0);
        end

        done = 1'b0;
        req  = 4'b1001;
        step();
        expect_out("abandon_handover", 4'b1000, 2'd3, 1'b1, 1'b0);

        req = 4'b0000;
        step();
        expect_out("idle_ptr0", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0001;
        step();
        expect_out("preempt_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("preempt_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        expect_out("preempt_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
        step();
        expect_out("preempt_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);

        req = 4'b0000;
        step();
        expect_out("idle_ptr2", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0001;
        step();
        expect_out("done_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("done_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        expect_out("done_beats_preempt", 4'b0010, 2'd1, 1'b1, 1'b0);

        // lone requester with done: one-cycle bubble before re-grant
        req = 4'b0010;
        step();
        expect_out("bubble_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("bubble_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        done = 1'b0;
        req  = 4'b1000;
        step();
        expect_out("owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        step();
        expect_out("owner3_hold2", 4'b1000, 2'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        expect_out("reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1010;
        step();
        expect_out("after_reset_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
